// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit. It takes one
// WIDTH-cycle pass per request and stalls the pipeline through Busy while it runs.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no operation pending; Start latches operands
// COMPUTE | one multiply/divide iteration per cycle, count = iteration
// DONE    | results valid, done=1; Start here chains the next operation
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               opDiv;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remNext;
  logic [WIDTH-1:0]   quoNext;
  logic               lastIter;
  logic               accept;

  // One iteration of each algorithm; only the one selected by opDiv is used for results.
  always_comb begin
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opA} : '0);
    prodNext = {sum, prod[WIDTH-1:1]};
    remShift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    remNext  = remShift;
    quoNext  = {quo[WIDTH-2:0], 1'b0};
    if (remShift >= {1'b0, opB}) begin
      remNext    = remShift - {1'b0, opB};
      quoNext[0] = 1'b1;
    end
  end

  assign lastIter = (count == CW'(WIDTH - 1));
  assign accept   = Start & ((state == IDLE) | (state == DONE));
  assign Busy     = (state == COMPUTE) | accept;
  assign done     = (state == DONE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      count   <= '0;
      opDiv   <= 1'b0;
      opA     <= '0;
      opB     <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state <= COMPUTE;
            count <= '0;
            opDiv <= MCycleOp;
            opA   <= Operand1;
            opB   <= Operand2;
            prod  <= {{WIDTH{1'b0}}, Operand2};
            rem   <= '0;
            quo   <= Operand1;
          end else begin
            state <= IDLE;
          end
        end
        COMPUTE: begin
          count <= count + CW'(1);
          prod  <= prodNext;
          rem   <= remNext;
          quo   <= quoNext;
          if (lastIter) begin
            state <= DONE;
            if (opDiv) begin
              Result1 <= quoNext;
              Result2 <= remNext[WIDTH-1:0];
            end else begin
              Result1 <= prodNext[WIDTH-1:0];
              Result2 <= prodNext[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: drivers push arithmetic-model results, a
// negedge monitor pops one per done pulse and compares {Result2, Result1}.
module tb_mcycle_unit;
  localparam int WIDTH = 32;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  int          doneSeen = 0;
  logic [63:0] expQ[$];

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Reference: plain arithmetic, packed as {high/remainder, low/quotient}.
  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (!op) begin
      p = 64'(a) * 64'(b);
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!Reset && done === 1'b1) begin
      doneSeen++;
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpectedDone: got done=1 at %0t, expected no pending operation", $time);
      end else begin
        check("result", {Result2, Result1}, expQ.pop_front());
      end
    end
  end

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input bit push);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    if (push) expQ.push_back(model(op, a, b));
  endtask

  // Called in cycle 0 of an operation (startC=0) or just after a chained done (startC=1).
  task automatic track(input string tag, input int startC, input int glitchAt, input bit chain,
                       input logic cop, input logic [31:0] ca, input logic [31:0] cb);
    int lat = -1;
    int busyBad = 0;
    logic busyAtDone = 1'b0;
    if (startC == 1) begin
      @(posedge CLK); #1;
      Start = 1'b0;
    end
    for (int c = startC; c <= WIDTH + 4; c++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        lat = c;
        busyAtDone = Busy;
        break;
      end
      if (Busy !== 1'b1) busyBad++;
      @(posedge CLK); #1;
      Start = 1'b0;
      if (c + 1 == glitchAt) begin
        Start    = 1'b1;
        MCycleOp = ~MCycleOp;
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
      if (chain && c + 1 == WIDTH + 1) issue(cop, ca, cb, 1'b1);
    end
    check({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
    check({tag, "_busyWindow"}, 64'(busyBad), 64'd0);
    check({tag, "_busyAtDone"}, 64'(busyAtDone), 64'(chain));
    if (!chain) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic runOp(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b1);
    track(tag, 0, -1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic runPair(input string tag, input logic op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic op2, input logic [31:0] a2, input logic [31:0] b2);
    issue(op1, a1, b1, 1'b1);
    track({tag, "_first"}, 0, -1, 1'b1, op2, a2, b2);
    track({tag, "_second"}, 1, -1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 20));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    Reset = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    check("reset_results", {Result2, Result1}, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    @(posedge CLK); #1;

    runOp("mul7x6", 1'b0, 32'd7, 32'd6);
    runOp("mulMax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div100by7", 1'b1, 32'd100, 32'd7);
    runOp("div80000000by1", 1'b1, 32'h8000_0000, 32'd1);
    runOp("divByZero", 1'b1, 32'h0000_1234, 32'd0);

    // Start with new operands mid-multiply must be ignored.
    issue(1'b0, 32'h0001_0003, 32'h0000_0101, 1'b1);
    track("startIgnored", 0, 10, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset in cycle 15 abandons the operation: no result is expected.
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(posedge CLK); #1;
      Start = 1'b0;
      if (c + 1 == 15) Reset = 1'b1;
      if (c + 1 == 16) Reset = 1'b0;
    end
    @(negedge CLK);
    check("abort_results", {Result2, Result1}, 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    base = doneSeen;
    repeat (40) @(posedge CLK);
    check("abort_noDone", 64'(doneSeen - base), 64'd0);
    #1;

    runPair("b2b", 1'b0, 32'd3, 32'd5, 1'b1, 32'd9, 32'd2);

    for (int i = 0; i < 16; i++) begin
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      op = 1'($urandom_range(0, 1));
      a  = randOperand();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : randOperand();
      if (i % 4 == 3)
        runPair("rndPair", op, a, b, ~op, randOperand(), randOperand());
      else
        runOp("rnd", op, a, b);
    end

    repeat (3) @(posedge CLK);
    check("queueDrained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
